hex_seq_monitor: RTL and testbench
==================================

// Module: hex_seq_monitor
// PURPOSE
//  Receive-side monitor for the 7-segment bus HEX[0:6] driven by the decade-counter display logic.
//  Decodes active-low segment patterns back to BCD digits, filters glitches, and checks the 0..MAX_DIGIT wrap sequence.
//  Flags illegal patterns and sequence skips, and counts errors for board-level self-test.
//  Sits on the same clock as the display driver.
// PARAMETERS
//  STABLE_CYCLES  2  consecutive identical samples required to accept a pattern (>=1)
//  MAX_DIGIT      9  last digit before wrap to 0 (1..9)
//  ERRCNT_W       8  width of saturating error counter
// PORTS
//  clock      in   1         rising-edge clock
//  resetn     in   1         asynchronous, active-low reset
//  HEX        in   [0:6]     segments a..g, active-low (HEX[0]=a)
//  digit      out  4         last accepted valid digit
//  digit_vld  out  1         1-cycle pulse: new valid digit accepted
//  pat_err    out  1         1-cycle pulse: illegal pattern accepted
//  seq_err    out  1         1-cycle pulse: valid digit != expected next digit
//  locked     out  1         level: sequence tracking active
//  err_count  out  ERRCNT_W  pat_err+seq_err events, saturates at all-ones
// BEHAVIOUR
//  - Reset (async assert, sync release): all outputs 0, state SYNC, last-accepted pattern = 7'b1111111.
//  - HEX registered into hex_q every clock. Stability counter restarts whenever hex_q changes.
//  - Accept event: hex_q equals itself for STABLE_CYCLES consecutive samples AND differs from last-accepted.
//    Outputs are registered; latency from HEX change to pulse = STABLE_CYCLES+1 clocks.
//    At most one accept per pattern hold. A glitch shorter than STABLE_CYCLES produces no event.
//  - Legal patterns: 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=1100000
//    7=0001111 8=0000000 9=0001100. Digits > MAX_DIGIT count as illegal.
//  - Blank 1111111: updates last-accepted only; no pulse, no error, state and digit unchanged.
//  - Any other pattern: illegal.
//  - FSM: SYNC (locked=0), TRACK (locked=1), BAD (locked=0).
//    SYNC : valid -> digit_vld, go TRACK. Illegal -> pat_err, go BAD.
//    TRACK: valid -> digit_vld. If digit != expected, also seq_err (reference becomes the new digit).
//           expected = (digit==MAX_DIGIT) ? 0 : digit+1. Illegal -> pat_err, go BAD.
//    BAD  : valid -> digit_vld, go TRACK, no sequence check (resync). Illegal -> pat_err, stay.
//  - pat_err and seq_err are mutually exclusive. Each asserts in the same cycle as any digit_vld.
//  - err_count += 1 per error pulse and holds at 2^ERRCNT_W-1.
//  - digit holds its value across illegal and blank patterns.
//  - resetn low mid-hold: event discarded; re-acquire starts from SYNC after release.
// CONFIGURATION
//  HEX_MON_SEQCHK_EN defined:
//    FSM as above.
//  HEX_MON_SEQCHK_EN undefined:
//    no sequence logic; seq_err=0 and locked=0 constantly.
//    digit_vld and pat_err still generated; err_count counts pat_err only.
// TESTING (STABLE_CYCLES=2, MAX_DIGIT=9, macro defined unless noted)
//  1 HEX=0000001 during reset, release -> all outputs 0 during reset;
//    3rd clock after release: digit_vld=1, digit=0; locked=1 next cycle.
//  2 Step 0..9,0, each held 4 clocks -> 11 digit_vld pulses with digits 0..9,0; seq_err never; err_count=0.
//  3 In TRACK, 3 then 5 -> digit_vld+seq_err same cycle, digit=5, err_count=1; then 6 -> no error.
//  4 Hold 1111110 4 clocks -> single pat_err, locked=0, err_count+1, digit unchanged;
//    then 7 -> digit_vld, locked=1, no seq_err.
//  5 Hold 2, 1-clock glitch to 1001111, back to 2 -> no pulses. Blank 1111111 for 5 clocks -> no pulses.
//  6 ERRCNT_W=2, 5 illegal/valid alternations -> err_count stops at 3.
//    Macro undefined, 3 then 5 -> no seq_err, locked=0.

Source files
------------

// File: rtl/hex_seq_monitor.sv
// hex_seq_monitor: receive-side monitor for an active-low 7-segment bus.
// Decodes segment patterns back to BCD digits and filters glitches. With
// sequence checking enabled, it also tracks the 0..MAX_DIGIT wrap sequence.
// Illegal patterns and sequence skips are counted in a saturating counter.
//
// Build option: define HEX_MON_SEQCHK_EN to enable the SYNC/TRACK/BAD
// sequence tracker. Without it, seq_err and locked are tied to 0, and
// err_count counts pattern errors only.
//
// Ports
//   clock      in   1         rising-edge clock
//   resetn     in   1         asynchronous active-low reset
//   HEX        in   [0:6]     segments a..g, active-low, HEX[0]=a
//   digit      out  4         last accepted valid digit
//   digit_vld  out  1         pulse: new valid digit accepted
//   pat_err    out  1         pulse: illegal pattern accepted
//   seq_err    out  1         pulse: digit differs from expected successor
//   locked     out  1         level: sequence tracking active
//   err_count  out  ERRCNT_W  saturating count of error pulses
module hex_seq_monitor #(
    parameter int unsigned STABLE_CYCLES = 2,
    parameter int unsigned MAX_DIGIT     = 9,
    parameter int unsigned ERRCNT_W      = 8
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [0:6]          HEX,
    output logic [3:0]          digit,
    output logic                digit_vld,
    output logic                pat_err,
    output logic                seq_err,
    output logic                locked,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [6:0]  BLANK = 7'b1111111;

    logic [6:0]          w_hex;
    logic [6:0]          r_hex_q;
    logic [6:0]          r_last;
    logic [CNT_W-1:0]    r_stab_cnt;
    logic [3:0]          r_digit;
    logic                r_vld;
    logic                r_pat;
    logic [ERRCNT_W-1:0] r_err;

    logic                w_accept;
    logic                w_blank;
    logic                w_dec_vld;
    logic [3:0]          w_dec_digit;
    logic [3:0]          w_digit_nxt;
    logic                w_vld_nxt;
    logic                w_pat_nxt;
    logic                w_seq_nxt;

    // Bit 6 of w_hex is segment a, which keeps the decode literals in a..g order.
    assign w_hex = HEX;

    // Input sample register and stability counter. The counter saturates at STABLE_CYCLES.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_hex_q    <= BLANK;
            r_stab_cnt <= '0;
        end else begin
            r_hex_q <= w_hex;
            if (w_hex != r_hex_q) begin
                r_stab_cnt <= CNT_W'(1);
            end else if (r_stab_cnt != CNT_W'(STABLE_CYCLES)) begin
                r_stab_cnt <= r_stab_cnt + CNT_W'(1);
            end
        end
    end

    // Comparing against the last accepted pattern allows only one accept per hold.
    assign w_accept = (r_stab_cnt == CNT_W'(STABLE_CYCLES)) && (r_hex_q != r_last);
    assign w_blank  = (r_hex_q == BLANK);

    // Segment decode. Digits above MAX_DIGIT are treated as illegal.
    always_comb begin
        w_dec_vld   = 1'b1;
        w_dec_digit = 4'd0;
        case (r_hex_q)
            7'b0000001: w_dec_digit = 4'd0;
            7'b1001111: w_dec_digit = 4'd1;
            7'b0010010: w_dec_digit = 4'd2;
            7'b0000110: w_dec_digit = 4'd3;
            7'b1001100: w_dec_digit = 4'd4;
            7'b0100100: w_dec_digit = 4'd5;
            7'b1100000: w_dec_digit = 4'd6;
            7'b0001111: w_dec_digit = 4'd7;
            7'b0000000: w_dec_digit = 4'd8;
            7'b0001100: w_dec_digit = 4'd9;
            default:    w_dec_vld   = 1'b0;
        endcase
        if (w_dec_digit > 4'(MAX_DIGIT)) begin
            w_dec_vld = 1'b0;
        end
    end

`ifdef HEX_MON_SEQCHK_EN
    localparam logic [1:0] S_SYNC  = 2'd0;
    localparam logic [1:0] S_TRACK = 2'd1;
    localparam logic [1:0] S_BAD   = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [3:0] w_expected;
    logic       r_locked;

    assign w_expected = (r_digit == 4'(MAX_DIGIT)) ? 4'd0 : r_digit + 4'd1;

    // Sequence tracker next-state and pulse logic. A blank pattern does not produce an event.
    always_comb begin
        w_state_nxt = r_state;
        w_digit_nxt = r_digit;
        w_vld_nxt   = 1'b0;
        w_pat_nxt   = 1'b0;
        w_seq_nxt   = 1'b0;
        if (w_accept && !w_blank) begin
            if (w_dec_vld) begin
                w_vld_nxt   = 1'b1;
                w_digit_nxt = w_dec_digit;
                w_state_nxt = S_TRACK;
                // Only TRACK checks the sequence. SYNC and BAD resync without a check.
                if ((r_state == S_TRACK) && (w_dec_digit != w_expected)) begin
                    w_seq_nxt = 1'b1;
                end
            end else begin
                w_pat_nxt   = 1'b1;
                w_state_nxt = S_BAD;
            end
        end
    end

    // FSM state register and registered locked level.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_SYNC;
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_locked <= (w_state_nxt == S_TRACK);
        end
    end

    logic r_seq;
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_seq <= 1'b0;
        end else begin
            r_seq <= w_seq_nxt;
        end
    end

    assign seq_err = r_seq;
    assign locked  = r_locked;
`else
    // Decode-only mode: report valid digits and illegal patterns.
    always_comb begin
        w_digit_nxt = r_digit;
        w_vld_nxt   = 1'b0;
        w_pat_nxt   = 1'b0;
        w_seq_nxt   = 1'b0;
        if (w_accept && !w_blank) begin
            if (w_dec_vld) begin
                w_vld_nxt   = 1'b1;
                w_digit_nxt = w_dec_digit;
            end else begin
                w_pat_nxt   = 1'b1;
            end
        end
    end

    assign seq_err = 1'b0;
    assign locked  = 1'b0;
`endif

    // Output registers, last accepted pattern and saturating error counter.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_last  <= BLANK;
            r_digit <= 4'd0;
            r_vld   <= 1'b0;
            r_pat   <= 1'b0;
            r_err   <= '0;
        end else begin
            if (w_accept) begin
                r_last <= r_hex_q;
            end
            r_digit <= w_digit_nxt;
            r_vld   <= w_vld_nxt;
            r_pat   <= w_pat_nxt;
            if ((w_pat_nxt || w_seq_nxt) && (r_err != {ERRCNT_W{1'b1}})) begin
                r_err <= r_err + ERRCNT_W'(1);
            end
        end
    end

    assign digit     = r_digit;
    assign digit_vld = r_vld;
    assign pat_err   = r_pat;
    assign err_count = r_err;

endmodule

// File: tb/tb_hex_seq_monitor.sv
// Directed bench for hex_seq_monitor. It runs the default instance through a
// vector table and a 2-bit error-counter instance through saturation.
module tb_hex_seq_monitor;

    localparam logic [6:0] P0 = 7'b0000001, P1 = 7'b1001111, P2 = 7'b0010010,
                           P3 = 7'b0000110, P4 = 7'b1001100, P5 = 7'b0100100,
                           P6 = 7'b1100000, P7 = 7'b0001111, P8 = 7'b0000000,
                           P9 = 7'b0001100, PB = 7'b1111111,
                           PX1 = 7'b1111110, PX2 = 7'b0111111;

    typedef struct {
        logic [6:0] hex;
        int         hold;
        int         vld;
        int         dig;
        int         pat;
        int         seq;
        int         lck;
        int         err;
        int         err_nd;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] hex = P0;
    logic [6:0] hex2 = PB;

    logic [3:0] digit, digit2;
    logic       digit_vld, pat_err, seq_err, locked;
    logic       digit_vld2, pat_err2, seq_err2, locked2;
    logic [7:0] err_count;
    logic [1:0] err_count2;

    int total = 0;
    int bad = 0;

    hex_seq_monitor u_dut (
        .clock(clk), .resetn(rst_n), .HEX(hex),
        .digit(digit), .digit_vld(digit_vld), .pat_err(pat_err),
        .seq_err(seq_err), .locked(locked), .err_count(err_count)
    );

    hex_seq_monitor #(.ERRCNT_W(2)) u_sat (
        .clock(clk), .resetn(rst_n), .HEX(hex2),
        .digit(digit2), .digit_vld(digit_vld2), .pat_err(pat_err2),
        .seq_err(seq_err2), .locked(locked2), .err_count(err_count2)
    );

    always #5 clk = ~clk;

`ifdef HEX_MON_SEQCHK_EN
    localparam int SEQ_ON = 1;
`else
    localparam int SEQ_ON = 0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_digit"}, 32'(digit), 0);
        check({tag, "_vld"},   32'(digit_vld), 0);
        check({tag, "_pat"},   32'(pat_err), 0);
        check({tag, "_seq"},   32'(seq_err), 0);
        check({tag, "_lck"},   32'(locked), 0);
        check({tag, "_err"},   32'(err_count), 0);
    endtask

    // Hold h through reset and release, then expect a digit_vld pulse on the third clock.
    task automatic reset_acquire(input string tag, input logic [6:0] h, input int exp_dig);
        @(negedge clk);
        rst_n = 1'b0;
        hex   = h;
        hex2  = PB;
        #1;
        check_all_zero({tag, "_inrst"});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("%s_vld_c%0d", tag, c), 32'(digit_vld), (c == 3) ? 1 : 0);
        end
        check({tag, "_digit"}, 32'(digit), 32'(exp_dig));
        @(posedge clk); #1;
        check({tag, "_lock"}, 32'(locked), 32'(SEQ_ON));
        check({tag, "_vld_off"}, 32'(digit_vld), 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int nv = 0;
        int np = 0;
        int ns = 0;
        int at = 0;
        @(negedge clk);
        hex = v.hex;
        for (int c = 1; c <= v.hold; c++) begin
            @(posedge clk); #1;
            if (digit_vld) begin nv++; at = c; end
            if (pat_err)   begin np++; if (at == 0) at = c; end
            if (seq_err)   ns++;
        end
        check($sformatf("v%0d_vld", idx), 32'(nv), 32'(v.vld));
        check($sformatf("v%0d_pat", idx), 32'(np), 32'(v.pat));
        if (v.vld + v.pat > 0) check($sformatf("v%0d_lat", idx), 32'(at), 3);
        check($sformatf("v%0d_digit", idx), 32'(digit), 32'(v.dig));
        if (SEQ_ON != 0) begin
            check($sformatf("v%0d_seq", idx), 32'(ns), 32'(v.seq));
            check($sformatf("v%0d_lck", idx), 32'(locked), 32'(v.lck));
            check($sformatf("v%0d_err", idx), 32'(err_count), 32'(v.err));
        end else begin
            check($sformatf("v%0d_seq", idx), 32'(ns), 0);
            check($sformatf("v%0d_lck", idx), 32'(locked), 0);
            check($sformatf("v%0d_err", idx), 32'(err_count), 32'(v.err_nd));
        end
    endtask

    vec_t vecs[23];

    initial begin
        //            hex  hold vld dig pat seq lck err nd
        vecs[0]  = '{P1,  4, 1, 1, 0, 0, 1, 0, 0};
        vecs[1]  = '{P2,  4, 1, 2, 0, 0, 1, 0, 0};
        vecs[2]  = '{P3,  4, 1, 3, 0, 0, 1, 0, 0};
        vecs[3]  = '{P4,  4, 1, 4, 0, 0, 1, 0, 0};
        vecs[4]  = '{P5,  4, 1, 5, 0, 0, 1, 0, 0};
        vecs[5]  = '{P6,  4, 1, 6, 0, 0, 1, 0, 0};
        vecs[6]  = '{P7,  4, 1, 7, 0, 0, 1, 0, 0};
        vecs[7]  = '{P8,  4, 1, 8, 0, 0, 1, 0, 0};
        vecs[8]  = '{P9,  4, 1, 9, 0, 0, 1, 0, 0};
        vecs[9]  = '{P0,  4, 1, 0, 0, 0, 1, 0, 0};
        vecs[10] = '{P1,  4, 1, 1, 0, 0, 1, 0, 0};
        vecs[11] = '{P2,  4, 1, 2, 0, 0, 1, 0, 0};
        vecs[12] = '{P3,  4, 1, 3, 0, 0, 1, 0, 0};
        vecs[13] = '{P5,  4, 1, 5, 0, 1, 1, 1, 0};
        vecs[14] = '{P6,  4, 1, 6, 0, 0, 1, 1, 0};
        vecs[15] = '{PX1, 4, 0, 6, 1, 0, 0, 2, 1};
        vecs[16] = '{PX2, 4, 0, 6, 1, 0, 0, 3, 2};
        vecs[17] = '{P7,  4, 1, 7, 0, 0, 1, 3, 2};
        vecs[18] = '{P2,  4, 1, 2, 0, 1, 1, 4, 2};
        vecs[19] = '{P1,  1, 0, 2, 0, 0, 1, 4, 2};
        vecs[20] = '{P2,  4, 0, 2, 0, 0, 1, 4, 2};
        vecs[21] = '{PB,  5, 0, 2, 0, 0, 1, 4, 2};
        vecs[22] = '{P3,  4, 1, 3, 0, 0, 1, 4, 2};

        // Power-up acquire of digit 0 held through reset.
        reset_acquire("por", P0, 0);

        for (int i = 0; i < 23; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset asserted mid-hold discards the pending event, then re-acquires from SYNC.
        @(negedge clk);
        hex = P4;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        reset_acquire("reacq", P4, 4);
        check("reacq_err", 32'(err_count), 0);

        // Saturating 2-bit error counter: illegal/valid alternation.
        check("sat_init", 32'(err_count2), 0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            hex2 = PX1;
            repeat (4) @(posedge clk);
            #1;
            check($sformatf("sat_err_%0d", k), 32'(err_count2), 32'((k > 3) ? 3 : k));
            @(negedge clk);
            hex2 = P0;
            repeat (4) @(posedge clk);
            #1;
            check($sformatf("sat_dig_%0d", k), 32'(digit2), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
